ocl_axil_portal_bridge: RTL and testbench

//  AXI4-Lite slave on the shell OCL (BAR) port, sitting between the shell's sh_ocl_*/ocl_sh_* pins and
//  the portal register fabric in mkAwsF1Top. Captures AW/W/AR independently, serialises them into
//  a single request/response portal channel with one access outstanding, returns B/R responses,
//  and decodes out-of-range addresses locally.

---
 rtl/ocl_axil_portal_bridge_if.sv | 49 ++++
 rtl/ocl_axil_portal_bridge.sv | 261 ++++++++++++++++++++++++++
 tb/tb_ocl_axil_portal_bridge.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ocl_axil_portal_bridge_if.sv
// Signal bundle between the shell OCL AXI4-Lite pins, the bridge and the portal request/response channel.
// slave: bridge side; master: shell + portal side (the bridge's environment).
interface ocl_axil_portal_bridge_if #(
    parameter int ADDR_W = 16
) ();
    logic              sh_ocl_awvalid;
    logic [31:0]       sh_ocl_awaddr;
    logic              ocl_sh_awready;
    logic              sh_ocl_wvalid;
    logic [31:0]       sh_ocl_wdata;
    logic [3:0]        sh_ocl_wstrb;
    logic              ocl_sh_wready;
    logic              ocl_sh_bvalid;
    logic [1:0]        ocl_sh_bresp;
    logic              sh_ocl_bready;
    logic              sh_ocl_arvalid;
    logic [31:0]       sh_ocl_araddr;
    logic              ocl_sh_arready;
    logic              ocl_sh_rvalid;
    logic [31:0]       ocl_sh_rdata;
    logic [1:0]        ocl_sh_rresp;
    logic              sh_ocl_rready;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              rsp_valid;
    logic [31:0]       rsp_data;

    modport slave (
        input  sh_ocl_awvalid, sh_ocl_awaddr, sh_ocl_wvalid, sh_ocl_wdata, sh_ocl_wstrb,
        input  sh_ocl_bready, sh_ocl_arvalid, sh_ocl_araddr, sh_ocl_rready,
        input  req_ready, rsp_valid, rsp_data,
        output ocl_sh_awready, ocl_sh_wready, ocl_sh_bvalid, ocl_sh_bresp,
        output ocl_sh_arready, ocl_sh_rvalid, ocl_sh_rdata, ocl_sh_rresp,
        output req_valid, req_write, req_addr, req_wdata, req_wstrb
    );

    modport master (
        output sh_ocl_awvalid, sh_ocl_awaddr, sh_ocl_wvalid, sh_ocl_wdata, sh_ocl_wstrb,
        output sh_ocl_bready, sh_ocl_arvalid, sh_ocl_araddr, sh_ocl_rready,
        output req_ready, rsp_valid, rsp_data,
        input  ocl_sh_awready, ocl_sh_wready, ocl_sh_bvalid, ocl_sh_bresp,
        input  ocl_sh_arready, ocl_sh_rvalid, ocl_sh_rdata, ocl_sh_rresp,
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb
    );
endinterface

// File: rtl/ocl_axil_portal_bridge.sv
// AXI4-Lite OCL slave: one-deep AW/W/AR slots serialised onto a single-outstanding portal channel.
// Define OCL_TIMEOUT_EN to add a downstream response timeout (SLVERR after TIMEOUT_CYCLES in WAIT).
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | arbitrate pending write (AW+W) vs read (AR), decode address
// ST_REQ  | req_valid held with stable fields until req_ready
// ST_WAIT | waiting for the portal's rsp_valid pulse
// ST_RESP | bvalid or rvalid held until the shell accepts it
module ocl_axil_portal_bridge #(
    parameter int          ADDR_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_main_a0,
    input  logic                    rst_main,
    ocl_axil_portal_bridge_if.slave bus
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_e;

    state_e            state_q, state_d;
    logic              prio_wr_q, prio_wr_d;
    logic              is_wr_q, is_wr_d;
    logic              aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
    logic              aw_bad_q, aw_bad_d, ar_bad_q, ar_bad_d;
    logic [ADDR_W-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
    logic [31:0]       w_data_q, w_data_d;
    logic [3:0]        w_strb_q, w_strb_d;
    logic              awready_q, wready_q, arready_q;
    logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              req_valid_q, req_valid_d, req_write_q, req_write_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [31:0]       req_wdata_q, req_wdata_d;
    logic [3:0]        req_wstrb_q, req_wstrb_d;
    logic              aw_hs, w_hs, ar_hs;
    logic              wr_elig, rd_elig, pick_wr, pick_bad;
    logic              unused_bits;
`ifdef OCL_TIMEOUT_EN
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    logic [31:0]       tmo_cnt_q, tmo_cnt_d;

    assign unused_bits = ^{bus.sh_ocl_awaddr[1:0], bus.sh_ocl_araddr[1:0]};
`else
    assign unused_bits = ^{bus.sh_ocl_awaddr[1:0], bus.sh_ocl_araddr[1:0], TIMEOUT_CYCLES[0]};
`endif

    assign aw_hs = bus.sh_ocl_awvalid & awready_q;
    assign w_hs  = bus.sh_ocl_wvalid  & wready_q;
    assign ar_hs = bus.sh_ocl_arvalid & arready_q;

    always_comb begin
        state_d     = state_q;
        prio_wr_d   = prio_wr_q;
        is_wr_d     = is_wr_q;
        aw_full_d   = aw_full_q;
        w_full_d    = w_full_q;
        ar_full_d   = ar_full_q;
        aw_bad_d    = aw_bad_q;
        ar_bad_d    = ar_bad_q;
        aw_addr_d   = aw_addr_q;
        ar_addr_d   = ar_addr_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        bvalid_d    = bvalid_q;
        rvalid_d    = rvalid_q;
        bresp_d     = bresp_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        req_valid_d = req_valid_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        wr_elig     = aw_full_q & w_full_q;
        rd_elig     = ar_full_q;
        pick_wr     = wr_elig & (~rd_elig | prio_wr_q);
        pick_bad    = pick_wr ? aw_bad_q : ar_bad_q;
`ifdef OCL_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif

        // Slot capture; a full slot never handshakes, so the frees below cannot collide with it.
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = {bus.sh_ocl_awaddr[ADDR_W-1:2], 2'b00};
            aw_bad_d  = |bus.sh_ocl_awaddr[31:ADDR_W];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = bus.sh_ocl_wdata;
            w_strb_d = bus.sh_ocl_wstrb;
        end
        if (ar_hs) begin
            ar_full_d = 1'b1;
            ar_addr_d = {bus.sh_ocl_araddr[ADDR_W-1:2], 2'b00};
            ar_bad_d  = |bus.sh_ocl_araddr[31:ADDR_W];
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_elig | rd_elig) begin
                    is_wr_d = pick_wr;
                    if (wr_elig & rd_elig) prio_wr_d = ~prio_wr_q;
                    if (pick_bad) begin
                        state_d = ST_RESP;
                        if (pick_wr) begin
                            aw_full_d = 1'b0;
                            w_full_d  = 1'b0;
                            bvalid_d  = 1'b1;
                            bresp_d   = RESP_DECERR;
                        end else begin
                            ar_full_d = 1'b0;
                            rvalid_d  = 1'b1;
                            rresp_d   = RESP_DECERR;
                            rdata_d   = '0;
                        end
                    end else begin
                        state_d     = ST_REQ;
                        req_valid_d = 1'b1;
                        req_write_d = pick_wr;
                        req_addr_d  = pick_wr ? aw_addr_q : ar_addr_q;
                        req_wdata_d = pick_wr ? w_data_q : '0;
                        req_wstrb_d = pick_wr ? w_strb_q : '0;
                    end
                end
            end
            ST_REQ: begin
                if (bus.req_ready) begin
                    state_d     = ST_WAIT;
                    req_valid_d = 1'b0;
                    if (is_wr_q) begin
                        aw_full_d = 1'b0;
                        w_full_d  = 1'b0;
                    end else begin
                        ar_full_d = 1'b0;
                    end
`ifdef OCL_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (bus.rsp_valid) begin
                    state_d = ST_RESP;
                    if (is_wr_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = RESP_OKAY;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = RESP_OKAY;
                        rdata_d  = bus.rsp_data;
                    end
                end
`ifdef OCL_TIMEOUT_EN
                else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                    if (tmo_cnt_d == TIMEOUT_CYCLES) begin
                        state_d = ST_RESP;
                        if (is_wr_q) begin
                            bvalid_d = 1'b1;
                            bresp_d  = RESP_SLVERR;
                        end else begin
                            rvalid_d = 1'b1;
                            rresp_d  = RESP_SLVERR;
                            rdata_d  = 32'hDEAD_BEEF;
                        end
                    end
                end
`endif
            end
            ST_RESP: begin
                if ((bvalid_q & bus.sh_ocl_bready) | (rvalid_q & bus.sh_ocl_rready)) begin
                    state_d  = ST_IDLE;
                    bvalid_d = 1'b0;
                    rvalid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            state_q     <= ST_IDLE;
            prio_wr_q   <= 1'b1;
            is_wr_q     <= 1'b0;
            aw_full_q   <= 1'b0;
            w_full_q    <= 1'b0;
            ar_full_q   <= 1'b0;
            aw_bad_q    <= 1'b0;
            ar_bad_q    <= 1'b0;
            aw_addr_q   <= '0;
            ar_addr_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            arready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= '0;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
`ifdef OCL_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            prio_wr_q   <= prio_wr_d;
            is_wr_q     <= is_wr_d;
            aw_full_q   <= aw_full_d;
            w_full_q    <= w_full_d;
            ar_full_q   <= ar_full_d;
            aw_bad_q    <= aw_bad_d;
            ar_bad_q    <= ar_bad_d;
            aw_addr_q   <= aw_addr_d;
            ar_addr_q   <= ar_addr_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            awready_q   <= ~aw_full_d;
            wready_q    <= ~w_full_d;
            arready_q   <= ~ar_full_d;
            bvalid_q    <= bvalid_d;
            rvalid_q    <= rvalid_d;
            bresp_q     <= bresp_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
`ifdef OCL_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign bus.ocl_sh_awready = awready_q;
    assign bus.ocl_sh_wready  = wready_q;
    assign bus.ocl_sh_arready = arready_q;
    assign bus.ocl_sh_bvalid  = bvalid_q;
    assign bus.ocl_sh_bresp   = bresp_q;
    assign bus.ocl_sh_rvalid  = rvalid_q;
    assign bus.ocl_sh_rresp   = rresp_q;
    assign bus.ocl_sh_rdata   = rdata_q;
    assign bus.req_valid      = req_valid_q;
    assign bus.req_write      = req_write_q;
    assign bus.req_addr       = req_addr_q;
    assign bus.req_wdata      = req_wdata_q;
    assign bus.req_wstrb      = req_wstrb_q;
endmodule

// File: tb/tb_ocl_axil_portal_bridge.sv
// Bench for ocl_axil_portal_bridge: directed cases plus randomized single accesses against a
// transaction-level model (address decode, expected portal request, expected response).
module tb_ocl_axil_portal_bridge;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   cyc;
    int   wait_start_cyc;
    int   last_valid_cyc;
    bit   portal_no_rsp;
    bit   fixed_rsp_en;
    logic [31:0] fixed_rsp;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    req_t        req_log[$];
    logic [31:0] rsp_q[$];

    ocl_axil_portal_bridge_if #(.ADDR_W(16)) bus ();

    ocl_axil_portal_bridge #(.ADDR_W(16), .TIMEOUT_CYCLES(16)) dut (
        .clk_main_a0 (clk),
        .rst_main    (rst),
        .bus         (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got=time_limit required=finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h required=%0h", tag, got, exp);
        end
    endtask

    // Model: a 32-bit address is in range iff its bits above ADDR_W are zero.
    function automatic logic [1:0] model_resp(input logic [31:0] a);
        return ((a >> 16) != 0) ? 2'b11 : 2'b00;
    endfunction

    always @(negedge clk)
        if (bus.ocl_sh_bvalid === 1'b1 && bus.ocl_sh_rvalid === 1'b1)
            check_eq("b_r_exclusive", 64'(bus.ocl_sh_bvalid & bus.ocl_sh_rvalid), 64'd0);

    // Portal model: acks each request after a random delay, then answers after another delay.
    initial begin : portal
        req_t r;
        int   d;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (bus.req_valid === 1'b1) begin
                r = '{bus.req_write, bus.req_addr, bus.req_wdata, bus.req_wstrb};
                d = $urandom_range(0, 3);
                repeat (d) @(negedge clk);
                check_eq("req_stable",
                         64'({bus.req_valid, bus.req_write, bus.req_addr, bus.req_wdata, bus.req_wstrb}),
                         64'({1'b1, r}));
                bus.req_ready = 1'b1;
                req_log.push_back(r);
                @(negedge clk);
                bus.req_ready  = 1'b0;
                wait_start_cyc = cyc;
                if (!portal_no_rsp) begin
                    d = $urandom_range(0, 3);
                    repeat (d) @(negedge clk);
                    bus.rsp_data = fixed_rsp_en ? fixed_rsp : 32'($urandom);
                    if (!r.wr) rsp_q.push_back(bus.rsp_data);
                    bus.rsp_valid = 1'b1;
                    @(negedge clk);
                    bus.rsp_valid = 1'b0;
                end
            end
        end
    end

    task automatic do_aw(input logic [31:0] a);
        int n;
        n = 0;
        bus.sh_ocl_awvalid = 1'b1;
        bus.sh_ocl_awaddr  = a;
        while (bus.ocl_sh_awready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check_eq("aw_accept", 64'(bus.ocl_sh_awready), 64'd1);
        @(negedge clk);
        bus.sh_ocl_awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] dat, input logic [3:0] strb);
        int n;
        n = 0;
        bus.sh_ocl_wvalid = 1'b1;
        bus.sh_ocl_wdata  = dat;
        bus.sh_ocl_wstrb  = strb;
        while (bus.ocl_sh_wready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check_eq("w_accept", 64'(bus.ocl_sh_wready), 64'd1);
        @(negedge clk);
        bus.sh_ocl_wvalid = 1'b0;
    endtask

    task automatic do_ar(input logic [31:0] a);
        int n;
        n = 0;
        bus.sh_ocl_arvalid = 1'b1;
        bus.sh_ocl_araddr  = a;
        while (bus.ocl_sh_arready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check_eq("ar_accept", 64'(bus.ocl_sh_arready), 64'd1);
        @(negedge clk);
        bus.sh_ocl_arvalid = 1'b0;
    endtask

    task automatic wait_b(input string tag, input logic [1:0] exp, input int hold);
        int n;
        n = 0;
        while (bus.ocl_sh_bvalid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        check_eq({tag, "_bvalid"}, 64'(bus.ocl_sh_bvalid), 64'd1);
        check_eq({tag, "_bresp"}, 64'(bus.ocl_sh_bresp), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, "_bhold"}, 64'({bus.ocl_sh_bvalid, bus.ocl_sh_bresp}), 64'({1'b1, exp}));
        end
        bus.sh_ocl_bready = 1'b1;
        @(negedge clk);
        bus.sh_ocl_bready = 1'b0;
        check_eq({tag, "_bdone"}, 64'(bus.ocl_sh_bvalid), 64'd0);
    endtask

    task automatic wait_r(input string tag, input logic [1:0] exp, input logic [31:0] exp_data,
                          input bit from_q, input int hold);
        int n;
        logic [31:0] ed;
        n  = 0;
        ed = exp_data;
        while (bus.ocl_sh_rvalid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        last_valid_cyc = cyc;
        check_eq({tag, "_rvalid"}, 64'(bus.ocl_sh_rvalid), 64'd1);
        if (from_q) begin
            check_eq({tag, "_rsp_seen"}, 64'(rsp_q.size()), 64'd1);
            if (rsp_q.size() > 0) ed = rsp_q.pop_front();
        end
        check_eq({tag, "_rresp"}, 64'(bus.ocl_sh_rresp), 64'(exp));
        check_eq({tag, "_rdata"}, 64'(bus.ocl_sh_rdata), 64'(ed));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, "_rhold"}, 64'({bus.ocl_sh_rvalid, bus.ocl_sh_rresp, bus.ocl_sh_rdata}),
                     64'({1'b1, exp, ed}));
            check_eq({tag, "_arready_in_resp"}, 64'(bus.ocl_sh_arready), 64'd1);
        end
        bus.sh_ocl_rready = 1'b1;
        @(negedge clk);
        bus.sh_ocl_rready = 1'b0;
        check_eq({tag, "_rdone"}, 64'(bus.ocl_sh_rvalid), 64'd0);
    endtask

    task automatic expect_req(input string tag, input logic wr, input logic [15:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb);
        req_t r;
        check_eq({tag, "_req_cnt"}, 64'(req_log.size()), 64'd1);
        if (req_log.size() > 0) begin
            r = req_log.pop_front();
            check_eq({tag, "_req_write"}, 64'(r.wr), 64'(wr));
            check_eq({tag, "_req_addr"}, 64'(r.addr), 64'(addr));
            if (wr) check_eq({tag, "_req_wdata"}, 64'({r.wstrb, r.wdata}), 64'({wstrb, wdata}));
        end
    endtask

    logic [31:0] a, dat;
    logic [3:0]  strb;
    logic [1:0]  er;
    bit          is_wr;
    int          hold, daw, dw;

    initial begin
        bus.sh_ocl_awvalid = 1'b0; bus.sh_ocl_awaddr = '0;
        bus.sh_ocl_wvalid  = 1'b0; bus.sh_ocl_wdata  = '0; bus.sh_ocl_wstrb = '0;
        bus.sh_ocl_bready  = 1'b0;
        bus.sh_ocl_arvalid = 1'b0; bus.sh_ocl_araddr = '0;
        bus.sh_ocl_rready  = 1'b0;
        portal_no_rsp = 1'b0;
        fixed_rsp_en  = 1'b0;
        fixed_rsp     = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_readies", 64'({bus.ocl_sh_awready, bus.ocl_sh_wready, bus.ocl_sh_arready}), 64'd0);
        check_eq("rst_valids", 64'({bus.ocl_sh_bvalid, bus.ocl_sh_rvalid, bus.req_valid}), 64'd0);
        check_eq("rst_resp_data", 64'({bus.ocl_sh_bresp, bus.ocl_sh_rresp, bus.ocl_sh_rdata}), 64'd0);
        check_eq("rst_req_fields", 64'({bus.req_write, bus.req_addr, bus.req_wstrb}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", 64'({bus.ocl_sh_awready, bus.ocl_sh_wready, bus.ocl_sh_arready}), 64'h7);

        // 1: AW and W in the same cycle
        fork
            do_aw(32'h0000_0010);
            do_w(32'hA5A5_0001, 4'hF);
        join
        wait_b("t1", 2'b00, 0);
        expect_req("t1", 1'b1, 16'h0010, 32'hA5A5_0001, 4'hF);

        // 2: W two cycles ahead of AW, exactly one response
        do_w(32'h5A5A_0002, 4'b0110);
        @(negedge clk);
        check_eq("t2_no_early_req", 64'({28'(req_log.size()), bus.req_valid}), 64'd0);
        do_aw(32'h0000_0024);
        wait_b("t2", 2'b00, 0);
        expect_req("t2", 1'b1, 16'h0024, 32'h5A5A_0002, 4'b0110);
        repeat (4) begin
            @(negedge clk);
            check_eq("t2_single_b", 64'(bus.ocl_sh_bvalid), 64'd0);
        end

        // 3: after reset, write and read tie -> write first, then read
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fixed_rsp_en = 1'b1;
        fixed_rsp    = 32'h1234_5678;
        fork
            do_aw(32'h0000_0040);
            do_w(32'h1111_2222, 4'hF);
            do_ar(32'h0000_0008);
        join
        wait_b("t3w", 2'b00, 0);
        expect_req("t3w", 1'b1, 16'h0040, 32'h1111_2222, 4'hF);
        wait_r("t3r", 2'b00, 32'h1234_5678, 1'b0, 0);
        expect_req("t3r", 1'b0, 16'h0008, 32'h0, 4'h0);
        void'(rsp_q.pop_front());
        fixed_rsp_en = 1'b0;

        // 3b: second tie -> priority has flipped to read
        fork
            do_aw(32'h0000_0044);
            do_w(32'h3333_4444, 4'h3);
            do_ar(32'h0000_000C);
        join
        wait_r("t3br", 2'b00, 32'h0, 1'b1, 0);
        expect_req("t3br", 1'b0, 16'h000C, 32'h0, 4'h0);
        wait_b("t3bw", 2'b00, 0);
        expect_req("t3bw", 1'b1, 16'h0044, 32'h3333_4444, 4'h3);

        // 4: out-of-range addresses decode locally
        do_ar(32'h0001_0000);
        wait_r("t4r", 2'b11, 32'h0, 1'b0, 2);
        check_eq("t4r_no_req", 64'(req_log.size()), 64'd0);
        fork
            do_aw(32'h8000_0004);
            do_w(32'hFFFF_FFFF, 4'hF);
        join
        wait_b("t4w", 2'b11, 1);
        check_eq("t4w_no_req", 64'(req_log.size()), 64'd0);

        // 5: rready held low for 5 cycles
        do_ar(32'h0000_0004);
        wait_r("t5", 2'b00, 32'h0, 1'b1, 5);
        expect_req("t5", 1'b0, 16'h0004, 32'h0, 4'h0);

`ifdef OCL_TIMEOUT_EN
        // 6: portal never answers the read
        portal_no_rsp = 1'b1;
        do_ar(32'h0000_0008);
        wait_r("t6", 2'b10, 32'hDEAD_BEEF, 1'b0, 0);
        check_eq("t6_timeout_cycles", 64'(last_valid_cyc - wait_start_cyc), 64'd16);
        expect_req("t6", 1'b0, 16'h0008, 32'h0, 4'h0);
        portal_no_rsp = 1'b0;
`endif

        // Randomized single accesses against the transaction model
        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom) & 32'h0000_FFFF;
            if ($urandom_range(0, 3) == 0) a[31:16] = 16'($urandom_range(1, 16'hFFFF));
            er    = model_resp(a);
            is_wr = 1'($urandom_range(0, 1));
            hold  = $urandom_range(0, 3);
            if (is_wr) begin
                dat  = 32'($urandom);
                strb = 4'($urandom_range(0, 15));
                daw  = $urandom_range(0, 3);
                dw   = $urandom_range(0, 3);
                fork
                    begin repeat (daw) @(negedge clk); do_aw(a); end
                    begin repeat (dw) @(negedge clk); do_w(dat, strb); end
                join
                wait_b("rnd_w", er, hold);
                if (er == 2'b00) expect_req("rnd_w", 1'b1, {a[15:2], 2'b00}, dat, strb);
            end else begin
                do_ar(a);
                wait_r("rnd_r", er, 32'h0, er == 2'b00, hold);
                if (er == 2'b00) expect_req("rnd_r", 1'b0, {a[15:2], 2'b00}, 32'h0, 4'h0);
            end
            check_eq("rnd_extra_req", 64'(req_log.size()), 64'd0);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
